// File: rtl/complex_fx_pkg.sv
// Shared definitions for the fixed-point complex arithmetic blocks:
// FSM state encoding, packed {re, im} field extraction and saturation limits.
package complex_fx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MULT,
        DIV,
        DONE
    } fxState_e;

    // Helpers work on a generously wide container; callers cast down to W.
    localparam int MAX_W = 64;

    function automatic logic [MAX_W-1:0] lowMask(input int w);
        return (w >= MAX_W) ? '1 : ((64'd1 << w) - 64'd1);
    endfunction

    function automatic logic [MAX_W-1:0] cplxRe(input logic [2*MAX_W-1:0] word, input int w);
        return MAX_W'(word >> w) & lowMask(w);
    endfunction

    function automatic logic [MAX_W-1:0] cplxIm(input logic [2*MAX_W-1:0] word, input int w);
        return MAX_W'(word) & lowMask(w);
    endfunction

    function automatic logic [MAX_W-1:0] satPosMag(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [MAX_W-1:0] satNegMag(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/fx_serial_udiv.sv
// Unsigned iterative restoring divider: load captures the dividend, each step
// retires one quotient bit MSB-first. After DW steps quotient_o = dividend / divisor.
module fx_serial_udiv
    import complex_fx_pkg::*;
#(
    parameter int DW  = 40,
    parameter int DVW = 33
) (
    input  logic           clk_i,
    input  logic           reset_i,
    input  logic           load_i,
    input  logic           step_i,
    input  logic [DW-1:0]  dividend_i,
    input  logic [DVW-1:0] divisor_i,
    output logic [DW-1:0]  quotient_o
);

    logic [DW-1:0]  quo_q, quo_d;
    logic [DVW-1:0] rem_q, rem_d;
    logic [DVW:0]   trial;

    // The dividend shifts out of quo_q as quotient bits shift in from the bottom.
    always_comb begin
        quo_d = quo_q;
        rem_d = rem_q;
        trial = {rem_q, quo_q[DW-1]};
        if (load_i) begin
            quo_d = dividend_i;
            rem_d = '0;
        end else if (step_i) begin
            if (trial >= {1'b0, divisor_i}) begin
                rem_d = DVW'(trial - {1'b0, divisor_i});
                quo_d = {quo_q[DW-2:0], 1'b1};
            end else begin
                rem_d = trial[DVW-1:0];
                quo_d = {quo_q[DW-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            quo_q <= '0;
            rem_q <= '0;
        end else begin
            quo_q <= quo_d;
            rem_q <= rem_d;
        end
    end

    assign quotient_o = quo_q;

endmodule

// File: rtl/complex_divide_fx.sv
// Iterative signed fixed-point complex divider A / B with divide-by-zero
// early-out, saturation reporting and a start / finish_flag handshake.
module complex_divide_fx
    import complex_fx_pkg::*;
#(
    parameter int W    = 16,
    parameter int FRAC = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [2*W-1:0] A,
    input  logic [2*W-1:0] B,
    output logic [2*W-1:0] result,
    output logic           finish_flag,
    output logic           busy,
    output logic           div_zero,
    output logic           sat
);

    localparam int N   = 2*W + FRAC;
    localparam int DW  = N;
    localparam int DVW = 2*W + 1;
    localparam int CW  = $clog2(N + 1);

    localparam logic [DW-1:0] PosLimit = DW'(satPosMag(W));
    localparam logic [DW-1:0] NegLimit = DW'(satNegMag(W));
    localparam logic [W-1:0]  PosOut   = W'(satPosMag(W));
    localparam logic [W-1:0]  NegOut   = W'(satNegMag(W));

    fxState_e state_q, state_d;

    logic [2*W-1:0] opA_q, opB_q;
    logic           signRe_q, signIm_q;
    logic [DVW-1:0] den_q;
    logic [CW-1:0]  cnt_q;
    logic [2*W-1:0] result_q;
    logic           finish_q, busy_q, divZero_q, sat_q;

    logic signed [W-1:0]   aRe, aIm, bRe, bIm;
    logic signed [DVW-1:0] aX, bX, cX, dX, numRe, numIm, denS;
    logic [DVW-1:0]        magRe, magIm;
    logic [DW-1:0]         quoRe, quoIm;
    logic [W:0]            clRe, clIm;
    logic                  denZero;

    // Returns {clipped, value}; q is the unsigned quotient magnitude.
    function automatic logic [W:0] clampComp(input logic [DW-1:0] q, input logic neg);
        logic [W:0] r;
        if (!neg) begin
            r = (q > PosLimit) ? {1'b1, PosOut} : {1'b0, q[W-1:0]};
        end else begin
            r = (q > NegLimit) ? {1'b1, NegOut} : {1'b0, -q[W-1:0]};
        end
        return r;
    endfunction

    assign aRe = W'(cplxRe((2*MAX_W)'(opA_q), W));
    assign aIm = W'(cplxIm((2*MAX_W)'(opA_q), W));
    assign bRe = W'(cplxRe((2*MAX_W)'(opB_q), W));
    assign bIm = W'(cplxIm((2*MAX_W)'(opB_q), W));

    // One spare bit keeps the extreme -2^(W-1) corner from overflowing.
    assign aX    = DVW'(aRe);
    assign bX    = DVW'(aIm);
    assign cX    = DVW'(bRe);
    assign dX    = DVW'(bIm);
    assign numRe = aX*cX + bX*dX;
    assign numIm = bX*cX - aX*dX;
    assign denS  = cX*cX + dX*dX;
    assign magRe = numRe[DVW-1] ? $unsigned(-numRe) : $unsigned(numRe);
    assign magIm = numIm[DVW-1] ? $unsigned(-numIm) : $unsigned(numIm);

    fx_serial_udiv #(.DW(DW), .DVW(DVW)) uDivRe (
        .clk_i      (clk),
        .reset_i    (reset),
        .load_i     (state_q == MULT),
        .step_i     (state_q == DIV),
        .dividend_i (DW'(magRe) << FRAC),
        .divisor_i  (den_q),
        .quotient_o (quoRe)
    );

    fx_serial_udiv #(.DW(DW), .DVW(DVW)) uDivIm (
        .clk_i      (clk),
        .reset_i    (reset),
        .load_i     (state_q == MULT),
        .step_i     (state_q == DIV),
        .dividend_i (DW'(magIm) << FRAC),
        .divisor_i  (den_q),
        .quotient_o (quoIm)
    );

    assign clRe    = clampComp(quoRe, signRe_q);
    assign clIm    = clampComp(quoIm, signIm_q);
    assign denZero = (den_q == '0);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = MULT;
            MULT:    state_d = (denS == '0) ? DONE : DIV;
            DIV:     if (cnt_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs only change in DONE, so they hold between operations.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            opA_q     <= '0;
            opB_q     <= '0;
            signRe_q  <= 1'b0;
            signIm_q  <= 1'b0;
            den_q     <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            finish_q  <= 1'b0;
            busy_q    <= 1'b0;
            divZero_q <= 1'b0;
            sat_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            finish_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        opA_q  <= A;
                        opB_q  <= B;
                        busy_q <= 1'b1;
                    end
                end
                MULT: begin
                    signRe_q <= numRe[DVW-1];
                    signIm_q <= numIm[DVW-1];
                    den_q    <= $unsigned(denS);
                    cnt_q    <= CW'(N - 1);
                end
                DIV: cnt_q <= cnt_q - CW'(1);
                DONE: begin
                    result_q  <= denZero ? '0 : {clRe[W-1:0], clIm[W-1:0]};
                    divZero_q <= denZero;
                    sat_q     <= !denZero && (clRe[W] || clIm[W]);
                    finish_q  <= 1'b1;
                    busy_q    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign result      = result_q;
    assign finish_flag = finish_q;
    assign busy        = busy_q;
    assign div_zero    = divZero_q;
    assign sat         = sat_q;

endmodule

// File: doc/complex_divide_fx.md
Name: complex_divide_fx

Overview:
- Parametrised, iterative, signed fixed-point complex divider: result = A / B, with A, B and result each packed as {real, imag}.
- Successor to the fixed 64-bit complex_division. Adds configurable component width and fraction bits, deterministic latency, divide-by-zero early-out, saturation reporting and a busy indication.
- Sits in the complex arithmetic datapath next to complex_multiply and uses the same start / finish_flag handshake.

Parameters:
- W, 16: component width in bits; signed two's complement.
- FRAC, 8: fractional bits per component (Q(W-FRAC).FRAC). Legal range 0..W-1.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- A  in  2*W  dividend; [2W-1:W] = real part a, [W-1:0] = imag part b.
- B  in  2*W  divisor; [2W-1:W] = real part c, [W-1:0] = imag part d.
- result  out  2*W  quotient {re, im}; same Q format as the inputs.
- finish_flag  out  1  one-cycle pulse when result is valid.
- busy  out  1  high from the cycle after start is accepted until finish_flag.
- div_zero  out  1  last operation had B = 0.
- sat  out  1  last operation saturated at least one component.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: result = 0, finish_flag = 0, busy = 0, div_zero = 0, sat = 0, state = IDLE. A reset mid-operation aborts it and produces no finish_flag.
- Maths: (a+jb)/(c+jd) = ((ac+bd) + j(bc-ad)) / (c²+d²).
  - Products are full precision, 2W bits each.
  - Numerators are 2W+1 bits signed; den = c²+d² is 2W+1 bits unsigned.
  - q = (num << FRAC) / den on magnitudes; the sign of num is then applied.
  - Rounding is truncation toward zero.
- Saturation: if q > 2^(W-1)-1, clamp to 2^(W-1)-1. If q < -2^(W-1), clamp to -2^(W-1). Either clamp sets sat.
- FSM states:
  - IDLE: start = 1 latches A and B and goes to MULT.
  - MULT (1 cycle): register the numerator magnitudes and signs, and den. If den = 0, go to DONE; otherwise go to DIV.
  - DIV (N = 2W+FRAC cycles): restoring division, one quotient bit per cycle. Real and imag run in parallel against the shared den.
  - DONE (1 cycle): apply signs and saturation, update result/sat/div_zero, pulse finish_flag, return to IDLE.
- Latency, counted from the edge that samples start to finish_flag high:
  - normal: N+2 cycles (42 for defaults).
  - den = 0: 2 cycles; result = 0, div_zero = 1, sat = 0.
- Handshake:
  - start is ignored in MULT, DIV and DONE, and the operand registers are not disturbed.
  - If start is held high continuously, a new operation is accepted on the first IDLE cycle, i.e. every N+3 cycles.
  - result, div_zero and sat hold their values until the next DONE.
- Boundary cases:
  - a = b = 0 with nonzero B gives result 0 and no flags.
  - A = B = {-2^(W-1), -2^(W-1)} must not overflow intermediates: numerator 2^(2W-1) fits within 2W magnitude bits.

Decomposition:
- Shared package complex_fx_pkg:
  - state encoding (IDLE/MULT/DIV/DONE)
  - helpers to extract re/im from a packed word
  - saturation limit constants as functions of W
- Sub-module fx_serial_udiv: unsigned iterative restoring divider with load/step, parametrised by dividend width. Instantiated twice (re, im) with a shared divisor and an iteration counter in the parent.

Test Plan (defaults W=16, FRAC=8; 1.0 = 0x0100):
- A=0x01000100, B=0x01000100 (1+j over 1+j) -> result 0x01000000, finish_flag exactly 42 cycles after start, sat=0, div_zero=0.
- A=0x01000000, B=0x00000100 (1 over j) -> result 0x0000FF00 (-j).
- A=0x03000400, B=0x01000200 ((3+4j)/(1+2j) = 2.2-0.4j) -> result 0x0233FF9A (truncation toward zero).
- A=0x01000100, B=0x00000000 -> finish_flag at 2 cycles, result 0x00000000, div_zero=1. A following normal op clears div_zero.
- A=0x7F000000, B=0x00010000 -> result 0x7FFF0000, sat=1. Repeat with A=0x81000000 -> result 0x80000000, sat=1.
- Protocol checks:
  - start held high: back-to-back finish_flag pulses 43 cycles apart, with an operand change mid-op ignored.
  - reset asserted at DIV cycle 10: no finish_flag, all outputs 0.
  - the next start completes normally.
